dds_table_ctrl: RTL

DDS_TABLE_CTRL -- requirements
Module: dds_table_ctrl

---
 rtl/dds_pkg.sv | 14 +
 rtl/dds_phase_acc.sv | 36 +++
 rtl/dds_table_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared state encoding and default widths for the DDS table controller.
package dds_pkg;

  localparam int DDS_ADDR_WIDTH  = 9;
  localparam int DDS_DATA_WIDTH  = 8;
  localparam int DDS_PHASE_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_phase_acc.sv
// dds_phase_acc: phase accumulator and table-address slice for DDS playback.
// The accumulator only advances on playback cycles; every other cycle parks it
// at zero so a new playback session always starts from table address 0.
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_advance,
  input  logic [PHASE_WIDTH-1:0] i_tuning_word,
  input  logic [ADDR_WIDTH-1:0]  i_offset,
  output logic [ADDR_WIDTH-1:0]  o_rd_addr
);

  logic [PHASE_WIDTH-1:0] r_phase;
  logic [ADDR_WIDTH-1:0]  w_phase_addr;

  // Accumulate modulo 2^PHASE_WIDTH while playing, otherwise hold phase at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= '0;
    end else if (i_advance) begin
      r_phase <= r_phase + i_tuning_word;
    end else begin
      r_phase <= '0;
    end
  end

  // Top phase bits address the table; the offset add wraps silently.
  assign w_phase_addr = r_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign o_rd_addr    = w_phase_addr + i_offset;

endmodule

// File: rtl/dds_table_ctrl.sv
// dds_table_ctrl: loads a waveform table into an external RAM and plays it
// back through a phase accumulator with a two-stage valid pipeline.
// Optional feature macro: DDS_PHASE_OFFSET_EN adds a phase_offset input that
// is added to the table address (latency unchanged).
module dds_table_ctrl
  import dds_pkg::*;
#(
  parameter int ADDR_WIDTH  = DDS_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DDS_DATA_WIDTH,
  parameter int PHASE_WIDTH = DDS_PHASE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   load_valid,
  input  logic [DATA_WIDTH-1:0]  load_data,
  output logic                   load_ready,
  output logic                   load_done,
  input  logic                   run_en,
  input  logic [PHASE_WIDTH-1:0] tuning_word,
`ifdef DDS_PHASE_OFFSET_EN
  input  logic [ADDR_WIDTH-1:0]  phase_offset,
`endif
  output logic [ADDR_WIDTH-1:0]  ram_wr_addr,
  output logic [DATA_WIDTH-1:0]  ram_din,
  output logic                   ram_wr_en,
  output logic [ADDR_WIDTH-1:0]  ram_rd_addr,
  input  logic [DATA_WIDTH-1:0]  ram_dout,
  output logic [DATA_WIDTH-1:0]  sample_out,
  output logic                   sample_valid,
  output logic                   table_valid
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  dds_state_e             r_state;
  dds_state_e             w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_ptr;
  logic                   r_load_done;
  logic                   r_table_valid;
  logic                   r_vld_p1;
  logic                   r_vld_p2;
  logic [DATA_WIDTH-1:0]  r_sample_p2;
  logic                   w_load_ready;
  logic                   w_wr_en;
  logic                   w_last_wr;
  logic                   w_enter_load;
  logic                   w_issue;
  logic [ADDR_WIDTH-1:0]  w_offset;

  // Next-state and load-side strobes; load_start has priority over run_en in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_load_ready = 1'b0;
    w_wr_en      = 1'b0;
    w_last_wr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (load_start) begin
          w_state_nxt = LOAD;
        end else if (run_en && r_table_valid) begin
          w_state_nxt = RUN;
        end
      end
      LOAD: begin
        w_load_ready = 1'b1;
        w_wr_en      = load_valid;
        w_last_wr    = load_valid && (r_ptr == LAST_ADDR);
        if (w_last_wr) begin
          w_state_nxt = IDLE;
        end
      end
      RUN: begin
        if (load_start) begin
          w_state_nxt = LOAD;
        end else if (!run_en) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A playback cycle is one spent in RUN that stays in RUN; leaving RUN flushes.
  assign w_enter_load = (w_state_nxt == LOAD) && (r_state != LOAD);
  assign w_issue      = (r_state == RUN) && (w_state_nxt == RUN);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write pointer, table-valid flag and the single-cycle load-complete pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr         <= '0;
      r_table_valid <= 1'b0;
      r_load_done   <= 1'b0;
    end else begin
      r_load_done <= w_last_wr;
      if (w_enter_load) begin
        r_ptr         <= '0;
        r_table_valid <= 1'b0;
      end else begin
        if (w_wr_en) begin
          r_ptr <= r_ptr + 1'b1;
        end
        if (w_last_wr) begin
          r_table_valid <= 1'b1;
        end
      end
    end
  end

`ifdef DDS_PHASE_OFFSET_EN
  assign w_offset = phase_offset;
`else
  assign w_offset = '0;
`endif

  // p0: read address issued from the accumulator.
  dds_phase_acc #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase_acc (
    .clk           (clk),
    .rst           (rst),
    .i_advance     (w_issue),
    .i_tuning_word (tuning_word),
    .i_offset      (w_offset),
    .o_rd_addr     (ram_rd_addr)
  );

  // p1: RAM data returns; p2: sample registered. Both stages drop on RUN exit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_sample_p2 <= '0;
    end else begin
      r_vld_p1 <= w_issue;
      r_vld_p2 <= r_vld_p1 && w_issue;
      if (r_vld_p1 && w_issue) begin
        r_sample_p2 <= ram_dout;
      end
    end
  end

  assign load_ready   = w_load_ready;
  assign load_done    = r_load_done;
  assign ram_wr_en    = w_wr_en;
  assign ram_wr_addr  = r_ptr;
  assign ram_din      = w_wr_en ? load_data : '0;
  assign sample_out   = r_sample_p2;
  assign sample_valid = r_vld_p2;
  assign table_valid  = r_table_valid;

endmodule
